// File: rtl/fft2d_corner_turn_if.sv
// Streaming sample bus for the 2-D FFT corner-turn buffer.
// FFT2D_CT_SOF_CHECK_EN adds the in_sof framing input.
interface fft2d_corner_turn_if #(
  parameter int W = 16
);
  logic [W-1:0] in_r;
  logic [W-1:0] in_i;
  logic         in_valid;
  logic         in_ready;
`ifdef FFT2D_CT_SOF_CHECK_EN
  logic         in_sof;
`endif
  logic [W-1:0] out_r;
  logic [W-1:0] out_i;
  logic         out_valid;
  logic         out_ready;
  logic         out_sof;
  logic         out_eoc;
  logic         sof_err;

  modport slave (
`ifdef FFT2D_CT_SOF_CHECK_EN
    input  in_sof,
`endif
    input  in_r, in_i, in_valid, out_ready,
    output in_ready, out_r, out_i, out_valid, out_sof, out_eoc, sof_err
  );

  modport master (
`ifdef FFT2D_CT_SOF_CHECK_EN
    output in_sof,
`endif
    output in_r, in_i, in_valid, out_ready,
    input  in_ready, out_r, out_i, out_valid, out_sof, out_eoc, sof_err
  );
endinterface

// File: rtl/fft2d_corner_turn.sv
// Ping-pong NxN corner-turn buffer: row-major in, column-major out, valid/ready both sides.
// Optional FFT2D_CT_SOF_CHECK_EN: in_sof resynchronises a misaligned input frame.
module fft2d_corner_turn #(
  parameter int N    = 8,
  parameter int W    = 16,
  parameter int LOGN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft2d_corner_turn_if.slave   bus
);
  localparam int AW = 2 * LOGN;
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_READING = 2'd2;
  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};
  localparam logic [LOGN-1:0] ROW_LAST = {LOGN{1'b1}};

  logic [2*W-1:0] mem_r [0:2*N*N-1];
  logic [1:0]     bank_state_r [0:1];
  logic [1:0]     bank_state_s [0:1];
  logic           wb_r, rb_r;
  logic [AW-1:0]  wcnt_r, rcnt_r;
  logic [W-1:0]   out_r_r, out_i_r;
  logic           out_valid_r, out_sof_r, out_eoc_r, sof_err_r;

  logic           in_ready_s, wr_fire_s, wr_last_s, sof_hit_s;
  logic           rd_avail_s, rd_fire_s, rd_last_s;
  logic [AW-1:0]  wr_idx_s;
  logic [LOGN-1:0] rd_row_s, rd_col_s;
  logic [2*W-1:0] rd_word_s;

  assign in_ready_s = (bank_state_r[wb_r] == ST_EMPTY);
  assign wr_fire_s  = bus.in_valid && in_ready_s;
`ifdef FFT2D_CT_SOF_CHECK_EN
  assign sof_hit_s  = wr_fire_s && bus.in_sof && (wcnt_r != IDX_ZERO);
`else
  assign sof_hit_s  = 1'b0;
`endif
  // A misaligned start-of-frame restarts the frame at index 0.
  assign wr_idx_s   = sof_hit_s ? IDX_ZERO : wcnt_r;
  assign wr_last_s  = wr_fire_s && (wr_idx_s == IDX_LAST);

  assign rd_avail_s = (bank_state_r[rb_r] == ST_FULL) || (bank_state_r[rb_r] == ST_READING);
  assign rd_fire_s  = (!out_valid_r || bus.out_ready) && rd_avail_s;
  assign rd_last_s  = rd_fire_s && (rcnt_r == IDX_LAST);
  // Column is the outer counter, row the inner one; stored address is row*N+col.
  assign rd_row_s   = rcnt_r[LOGN-1:0];
  assign rd_col_s   = rcnt_r[AW-1:LOGN];
  assign rd_word_s  = mem_r[{rb_r, rd_row_s, rd_col_s}];

  // Next bank state: write and read never target the same bank in one cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_state_s[b] = bank_state_r[b];
      if (wr_last_s && (wb_r == 1'(b))) begin
        bank_state_s[b] = ST_FULL;
      end else if (rd_last_s && (rb_r == 1'(b))) begin
        bank_state_s[b] = ST_EMPTY;
      end else if (rd_fire_s && (rb_r == 1'(b))) begin
        bank_state_s[b] = ST_READING;
      end else begin
        bank_state_s[b] = bank_state_r[b];
      end
    end
  end

  // Sample storage, intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[{wb_r, wr_idx_s}] <= {bus.in_r, bus.in_i};
    end
  end

  // Bank bookkeeping, counters and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state_r[0] <= ST_EMPTY;
      bank_state_r[1] <= ST_EMPTY;
      wb_r        <= 1'b0;
      rb_r        <= 1'b0;
      wcnt_r      <= IDX_ZERO;
      rcnt_r      <= IDX_ZERO;
      out_r_r     <= {W{1'b0}};
      out_i_r     <= {W{1'b0}};
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      out_eoc_r   <= 1'b0;
      sof_err_r   <= 1'b0;
    end else begin
      bank_state_r[0] <= bank_state_s[0];
      bank_state_r[1] <= bank_state_s[1];
      sof_err_r       <= sof_hit_s;
      if (wr_fire_s) begin
        wcnt_r <= wr_idx_s + IDX_ONE;
        if (wr_last_s) begin
          wb_r <= ~wb_r;
        end
      end
      if (rd_fire_s) begin
        out_r_r     <= rd_word_s[2*W-1:W];
        out_i_r     <= rd_word_s[W-1:0];
        out_valid_r <= 1'b1;
        out_sof_r   <= (rcnt_r == IDX_ZERO);
        out_eoc_r   <= (rd_row_s == ROW_LAST);
        rcnt_r      <= rcnt_r + IDX_ONE;
        if (rd_last_s) begin
          rb_r <= ~rb_r;
        end
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_r     = out_r_r;
  assign bus.out_i     = out_i_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sof   = out_sof_r;
  assign bus.out_eoc   = out_eoc_r;
  assign bus.sof_err   = sof_err_r;
endmodule

// File: tb/tb_fft2d_corner_turn.sv
// Scoreboard bench for fft2d_corner_turn (N=8, W=16); covers FFT2D_CT_SOF_CHECK_EN when defined.
module tb_fft2d_corner_turn;
  localparam int N = 8, W = 16, LOGN = 3, NN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft2d_corner_turn_if #(.W(W)) bus();
  fft2d_corner_turn #(.N(N), .W(W), .LOGN(LOGN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sof;
    logic         eoc;
  } smp_t;

  smp_t sb_q[$];
  smp_t held;
  int n_cmp = 0, n_err = 0, nout = 0, n_stall = 0, n_bubble = 0;
  logic rnd_en = 1'b0, stall_prev = 1'b0, hs_prev = 1'b0;
  logic [W-1:0] fr_re [NN];
  logic [W-1:0] fr_im [NN];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] pat(input int kind, input int r, input int c);
    logic [W-1:0] re, im;
    re = W'(r + c + 2);
    im = re;
    if (kind == 1) begin
      im = ~re;
      if (r == 1 && c == 2) re = 16'h8000;
      if (r == 6 && c == 5) re = 16'hFFFF;
      if (r == 3 && c == 3) im = 16'h8000;
      if (r == 7 && c == 0) im = 16'hFFFF;
    end else if (kind >= 2) begin
      re = W'(r * 37 + c * 101 + kind * 977);
      im = W'(kind * 31 - r * c * 53);
    end
    return {re, im};
  endfunction

  // Output monitor: scoreboard pop on each handshake, hold check while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {bus.out_r, bus.out_i, bus.out_sof, bus.out_eoc}, held);
      if (hs_prev && !bus.out_valid && sb_q.size() > 0) n_bubble++;
      hs_prev = bus.out_valid && bus.out_ready;
      stall_prev = bus.out_valid && !bus.out_ready;
      held = {bus.out_r, bus.out_i, bus.out_sof, bus.out_eoc};
      if (bus.out_valid && bus.out_ready) begin
        check("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) check("out_sample", held, sb_q.pop_front());
        nout++;
      end
    end
  end

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic sof);
    logic acc;
    int guard;
    bus.in_r = re;
    bus.in_i = im;
    bus.in_valid = 1'b1;
`ifdef FFT2D_CT_SOF_CHECK_EN
    bus.in_sof = sof;
`endif
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 400) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (!acc) n_stall++;
      if (rnd_en) bus.out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    bus.in_valid = 1'b0;
`ifdef FFT2D_CT_SOF_CHECK_EN
    bus.in_sof = 1'b0;
`endif
    check("in_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_frame(input int kind, input logic sof_first);
    logic [2*W-1:0] v;
    for (int idx = 0; idx < NN; idx++) begin
      v = pat(kind, idx / N, idx % N);
      fr_re[idx] = v[2*W-1:W];
      fr_im[idx] = v[W-1:0];
      send(v[2*W-1:W], v[W-1:0], sof_first && idx == 0);
      if (sof_first && idx == 0) check("sof_err_pulse", 64'(bus.sof_err), 64'd1);
      if (sof_first && idx == 1) check("sof_err_clear", 64'(bus.sof_err), 64'd0);
    end
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++)
        sb_q.push_back({fr_re[r*N+c], fr_im[r*N+c], 1'(c == 0 && r == 0), 1'(r == N-1)});
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_q.size() > 0 || bus.out_valid) && guard < 2000) begin
      @(posedge clk);
      #1;
      if (rnd_en) bus.out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    check("drain_done", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int base, s0, b0, guard;
    logic [2*W-1:0] v;
    bus.in_r = '0;
    bus.in_i = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
`ifdef FFT2D_CT_SOF_CHECK_EN
    bus.in_sof = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bus.out_r, bus.out_i, bus.out_valid, bus.out_sof, bus.out_eoc,
                          bus.sof_err, bus.in_ready}, {32'h0, 5'b00001});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single frame, latency and r+c+2 transpose
    send_frame(0, 1'b0);
    check("latency_pre", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("latency_first", {bus.out_valid, bus.out_r, bus.out_i, bus.out_sof}, {1'b1, 16'd2, 16'd2, 1'b1});
    drain();

    // 2: three back-to-back frames, no input stall, no output bubble
    s0 = n_stall;
    b0 = n_bubble;
    base = nout;
    send_frame(0, 1'b0);
    send_frame(2, 1'b0);
    send_frame(3, 1'b0);
    check("s2_in_stalls", 64'(n_stall - s0), 64'd0);
    drain();
    check("s2_bubbles", 64'(n_bubble - b0), 64'd0);
    check("s2_count", 64'(nout - base), 64'd192);

    // 3: downstream blocked for two frames, then released
    bus.out_ready = 1'b0;
    send_frame(4, 1'b0);
    send_frame(5, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("s3_blocked", {bus.in_ready, bus.out_valid}, 2'b01);
    base = nout;
    bus.out_ready = 1'b1;
    guard = 0;
    while ((nout - base) < 66 && guard < 200) begin
      @(posedge clk);
      #2;
      check("s3_in_ready", 64'(bus.in_ready), 64'((nout - base) >= 63));
      guard++;
    end
    drain();

    // 4: random backpressure with extreme values
    rnd_en = 1'b1;
    send_frame(1, 1'b0);
    send_frame(0, 1'b0);
    drain();
    rnd_en = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 5: reset during write and during read
    for (int i = 0; i < 30; i++) begin
      v = pat(6, i / N, i % N);
      send(v[2*W-1:W], v[W-1:0], 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check("s5_rst_write", {bus.out_r, bus.out_i, bus.out_valid, bus.out_sof, bus.out_eoc,
                           bus.sof_err, bus.in_ready}, {32'h0, 5'b00001});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(7, 1'b0);
    base = nout;
    guard = 0;
    while ((nout - base) < 20 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("s5_rst_read", {bus.out_r, bus.out_i, bus.out_valid, bus.out_sof, bus.out_eoc,
                          bus.sof_err, bus.in_ready}, {32'h0, 5'b00001});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s5_no_stale", 64'(bus.out_valid), 64'd0);
    send_frame(8, 1'b0);
    drain();

`ifdef FFT2D_CT_SOF_CHECK_EN
    // 6: misaligned in_sof after 20 samples restarts the frame
    for (int i = 0; i < 20; i++) begin
      v = pat(6, i / N, i % N);
      send(v[2*W-1:W], v[W-1:0], 1'b0);
      check("s6_no_err", 64'(bus.sof_err), 64'd0);
    end
    send_frame(9, 1'b1);
    drain();
`else
    check("sof_err_tied", 64'(bus.sof_err), 64'd0);
`endif

    check("sb_empty_end", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
